// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared types for the parameterised register file
package reg_file_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        FIN   = 2'd2
    } state_e;

    localparam int MIN_DEPTH = 2;
    localparam int MAX_DEPTH = 64;

endpackage

// File: rtl/reg_file_rdmux.sv
// rtl/reg_file_rdmux.sv - DEPTH:1 read multiplexer over a flattened register array
module reg_file_rdmux #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic [DEPTH*WIDTH-1:0] i_data,
    input  logic [AW-1:0]          i_sel,
    output logic [WIDTH-1:0]       o_data
);

    always_comb begin
        o_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_sel == AW'(i)) begin
                o_data = i_data[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/param_reg_file.sv
// rtl/param_reg_file.sv - 1W/2R register file with sequential clear engine
// Optional same-cycle write-to-read forwarding under PARAM_REG_FILE_BYPASS_EN.
module param_reg_file
    import reg_file_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             WE,
    input  logic [AW-1:0]    WA,
    input  logic [WIDTH-1:0] WD,
    input  logic [AW-1:0]    RA0,
    output logic [WIDTH-1:0] RD0,
    input  logic [AW-1:0]    RA1,
    output logic [WIDTH-1:0] RD1,
    input  logic             CLR,
    output logic             BUSY,
    output logic             DONE
);

    state_e                 r_state;
    state_e                 w_next_state;
    logic [AW-1:0]          r_cnt;
    logic [WIDTH-1:0]       r_mem [DEPTH];
    logic                   w_wr_en;
    logic                   w_clr_start;
    logic                   w_clr_last;
    logic [DEPTH*WIDTH-1:0] w_flat;
    logic [WIDTH-1:0]       w_rd0_mem;
    logic [WIDTH-1:0]       w_rd1_mem;

    assign w_clr_last = (r_cnt == AW'(DEPTH - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // CLR wins over WE in IDLE; both are ignored once the clear is running.
    always_comb begin
        w_next_state = r_state;
        w_wr_en      = 1'b0;
        w_clr_start  = 1'b0;
        BUSY         = 1'b0;
        DONE         = 1'b0;
        case (r_state)
            IDLE: begin
                if (CLR) begin
                    w_next_state = CLEAR;
                    w_clr_start  = 1'b1;
                end else begin
                    w_wr_en = WE;
                end
            end
            CLEAR: begin
                BUSY = 1'b1;
                if (w_clr_last) begin
                    w_next_state = FIN;
                end
            end
            FIN: begin
                BUSY         = 1'b1;
                DONE         = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt <= '0;
        end else if (w_clr_start) begin
            r_cnt <= '0;
        end else if (r_state == CLEAR) begin
            r_cnt <= r_cnt + AW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_state == CLEAR) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_en) begin
            r_mem[WA] <= WD;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign w_flat[g*WIDTH +: WIDTH] = r_mem[g];
    end

    reg_file_rdmux #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_rdmux0 (
        .i_data (w_flat),
        .i_sel  (RA0),
        .o_data (w_rd0_mem)
    );

    reg_file_rdmux #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_rdmux1 (
        .i_data (w_flat),
        .i_sel  (RA1),
        .o_data (w_rd1_mem)
    );

`ifdef PARAM_REG_FILE_BYPASS_EN
    assign RD0 = (w_wr_en && (RA0 == WA)) ? WD : w_rd0_mem;
    assign RD1 = (w_wr_en && (RA1 == WA)) ? WD : w_rd1_mem;
`else
    assign RD0 = w_rd0_mem;
    assign RD1 = w_rd1_mem;
`endif

endmodule

// File: tb/tb_param_reg_file.sv
// tb/tb_param_reg_file.sv - self-checking bench for param_reg_file
module tb_param_reg_file;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
`ifdef PARAM_REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             WE;
    logic [AW-1:0]    WA;
    logic [WIDTH-1:0] WD;
    logic [AW-1:0]    RA0;
    logic [WIDTH-1:0] RD0;
    logic [AW-1:0]    RA1;
    logic [WIDTH-1:0] RD1;
    logic             CLR;
    logic             BUSY;
    logic             DONE;

    param_reg_file #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N), .WE(WE), .WA(WA), .WD(WD),
        .RA0(RA0), .RD0(RD0), .RA1(RA1), .RD1(RD1),
        .CLR(CLR), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic             we;
        logic [AW-1:0]    wa;
        logic [WIDTH-1:0] wd;
        logic [AW-1:0]    ra0;
        logic [AW-1:0]    ra1;
        logic [WIDTH-1:0] e0;
        logic [WIDTH-1:0] e1;
    } vec_t;

    vec_t             tbl[$];
    logic [WIDTH-1:0] pat [DEPTH];
    logic [WIDTH-1:0] m_mem [DEPTH];
    int               m_age;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (BUSY && k < 30) begin
            step();
            k++;
        end
        chk("idle_timeout", 16'(BUSY), 16'd0);
    endtask

    task automatic fill_pattern();
        CLR = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            WE = 1'b1; WA = AW'(i); WD = pat[i];
            step();
        end
        WE = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nb, nd, done_at;
        logic [WIDTH-1:0] e0, e1;

        pat = '{16'h0000, 16'h0001, 16'h0010, 16'h0011,
                16'h0100, 16'h0101, 16'h0110, 16'h0111};

        tbl.push_back('{1'b1, 3'd3, 16'h0011, 3'd0, 3'd2, 16'h0000, 16'h0000});
        tbl.push_back('{1'b0, 3'd0, 16'h0000, 3'd3, 3'd2, 16'h0011, 16'h0000});
        for (int i = 0; i < DEPTH; i++) begin
            tbl.push_back('{1'b1, AW'(i), pat[i], 3'd3, 3'd3, 16'h0011, 16'h0011});
        end

        RST_N = 1'b0; WE = 1'b0; CLR = 1'b0; WA = '0; WD = '0; RA0 = '0; RA1 = '0;
        #12;
        chk("reset_busy", 16'(BUSY), 16'd0);
        chk("reset_done", 16'(DONE), 16'd0);
        chk("reset_rd0", RD0, 16'h0000);
        RST_N = 1'b1;

        foreach (tbl[i]) begin
            WE = tbl[i].we; WA = tbl[i].wa; WD = tbl[i].wd;
            RA0 = tbl[i].ra0; RA1 = tbl[i].ra1;
            #1;
            chk($sformatf("tbl%0d_rd0", i), RD0, tbl[i].e0);
            chk($sformatf("tbl%0d_rd1", i), RD1, tbl[i].e1);
            step();
        end
        WE = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            RA0 = AW'(i);
            #1;
            chk($sformatf("sweep_rd0_%0d", i), RD0, pat[i]);
            step();
            step();
        end

        // Clear with WE and CLR held high throughout the busy window.
        RA0 = 3'd7; RA1 = 3'd0;
        CLR = 1'b1; WE = 1'b1; WA = 3'd5; WD = 16'hABCD;
        step();
        nb = 0; nd = 0; done_at = 0;
        for (int c = 1; c <= 20; c++) begin
            #1;
            if (c == 5) begin
                chk("midclr_uncleared", RD0, pat[7]);
                chk("midclr_cleared", RD1, 16'h0000);
            end
            if (BUSY) nb++;
            if (DONE) begin
                nd++;
                done_at = c;
            end
            if (!BUSY) break;
            step();
        end
        CLR = 1'b0; WE = 1'b0;
        chk("clr_busy_cycles", 16'(nb), 16'd9);
        chk("clr_done_count", 16'(nd), 16'd1);
        chk("clr_done_cycle", 16'(done_at), 16'd9);
        for (int i = 0; i < DEPTH; i++) begin
            RA0 = AW'(i); RA1 = AW'(DEPTH - 1 - i);
            #1;
            chk($sformatf("clr_zero_p0_%0d", i), RD0, 16'h0000);
            chk($sformatf("clr_zero_p1_%0d", i), RD1, 16'h0000);
        end

        // CLR beats WE in IDLE: reg 2 still holds its old value right after the start.
        WE = 1'b1; WA = 3'd2; WD = 16'h2222;
        step();
        WD = 16'hBEEF; CLR = 1'b1; RA0 = 3'd2;
        #1;
        chk("prio_no_fwd", RD0, 16'h2222);
        step();
        WE = 1'b0; CLR = 1'b0;
        #1;
        chk("prio_write_dropped", RD0, 16'h2222);
        wait_idle();

        // Reset at CNT=4 in the middle of a clear.
        fill_pattern();
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        repeat (4) step();
        chk("midrst_pre_busy", 16'(BUSY), 16'd1);
        RST_N = 1'b0;
        #1;
        chk("midrst_busy", 16'(BUSY), 16'd0);
        chk("midrst_done", 16'(DONE), 16'd0);
        for (int i = 0; i < DEPTH; i++) begin
            RA0 = AW'(i);
            #1;
            chk($sformatf("midrst_zero_%0d", i), RD0, 16'h0000);
        end
        RST_N = 1'b1;
        nd = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (DONE || BUSY) nd++;
        end
        chk("midrst_no_done", 16'(nd), 16'd0);

        // Same-cycle forwarding depends on the build.
        WE = 1'b1; WA = 3'd6; WD = 16'h5555;
        step();
        WD = 16'h1234; RA1 = 3'd6;
        #1;
        chk("bypass_same_cycle", RD1, BYP ? 16'h1234 : 16'h5555);
        step();
        WE = 1'b0;
        #1;
        chk("bypass_next_cycle", RD1, 16'h1234);

        // Randomised run against a reference model.
        RST_N = 1'b0;
        #1;
        RST_N = 1'b1;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_age = -1;
        for (int n = 0; n < 400; n++) begin
            WE  = 1'($urandom_range(0, 1));
            WA  = AW'($urandom_range(0, DEPTH - 1));
            WD  = WIDTH'($urandom);
            RA0 = AW'($urandom_range(0, DEPTH - 1));
            RA1 = AW'($urandom_range(0, DEPTH - 1));
            CLR = ($urandom_range(0, 19) == 0);
            #1;
            e0 = m_mem[RA0];
            e1 = m_mem[RA1];
            if (BYP && m_age < 0 && WE && !CLR) begin
                if (RA0 == WA) e0 = WD;
                if (RA1 == WA) e1 = WD;
            end
            chk($sformatf("rnd%0d_rd0", n), RD0, e0);
            chk($sformatf("rnd%0d_rd1", n), RD1, e1);
            chk($sformatf("rnd%0d_busy", n), 16'(BUSY), 16'(m_age >= 0));
            chk($sformatf("rnd%0d_done", n), 16'(DONE), 16'(m_age == DEPTH));
            if (m_age >= 0) begin
                if (m_age < DEPTH) m_mem[m_age] = '0;
                m_age++;
                if (m_age > DEPTH) m_age = -1;
            end else if (CLR) begin
                m_age = 0;
            end else if (WE) begin
                m_mem[WA] = WD;
            end
            step();
        end
        WE = 1'b0; CLR = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
